// File: rtl/memory_pkg.sv
// Shared Beta opcode constants and decode helpers for the memory stage.
package memory_pkg;

    localparam logic [5:0]  OPCODE_LD    = 6'h18;
    localparam logic [5:0]  OPCODE_ST    = 6'h19;
    localparam logic [5:0]  OPCODE_JMP   = 6'h1B;
    localparam logic [5:0]  OPCODE_BEQ   = 6'h1C;
    localparam logic [5:0]  OPCODE_BNE   = 6'h1D;
    localparam logic [5:0]  OPCODE_LDR   = 6'h1F;
    localparam logic [31:0] NOP_ENCODING = 32'h83FFF800;
    localparam logic [4:0]  REG_ZERO     = 5'd31;

    typedef enum logic [0:0] {
        PORT_IDLE = 1'b0,
        PORT_WAIT = 1'b1
    } port_state_e;

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OPCODE_LD) || (op == OPCODE_LDR);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        return is_load_op(op) || (op == OPCODE_ST);
    endfunction

    // Loads write Rc too, even though their opcode[5] is clear.
    function automatic logic writes_rc(input logic [5:0] op);
        return op[5] || is_load_op(op) || (op == OPCODE_JMP) ||
               (op == OPCODE_BEQ) || (op == OPCODE_BNE);
    endfunction

endpackage

// File: rtl/memory_dmem_port.sv
// Data-memory request sequencer: IDLE/WAIT handshake, stall and completion strobe.
module memory_dmem_port
    import memory_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic mem_op,
    input  logic dmem_ready,
    output logic dmem_req,
    output logic mem_stall,
    output logic done
);

    port_state_e state_r;
    port_state_e state_next_s;
    logic        req_s;

    // State register; reset abandons any outstanding access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= PORT_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and request decode.
    always_comb begin
        state_next_s = state_r;
        req_s        = 1'b0;
        case (state_r)
            PORT_IDLE: begin
                req_s = mem_op;
                if (mem_op && !dmem_ready) begin
                    state_next_s = PORT_WAIT;
                end else begin
                    state_next_s = PORT_IDLE;
                end
            end
            PORT_WAIT: begin
                req_s = 1'b1;
                if (dmem_ready) begin
                    state_next_s = PORT_IDLE;
                end else begin
                    state_next_s = PORT_WAIT;
                end
            end
            default: begin
                req_s        = 1'b0;
                state_next_s = PORT_IDLE;
            end
        endcase
    end

    assign dmem_req  = req_s;
    assign mem_stall = req_s & ~dmem_ready;
    assign done      = req_s & dmem_ready;

endmodule

// File: rtl/memory.sv
// Beta memory pipeline stage: stage registers, LD/LDR/ST access, WB muxing and forwarding.
module memory
    import memory_pkg::*;
#(
    parameter logic [31:0] NOP_INST   = NOP_ENCODING,
    parameter bit          ALIGN_ADDR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_mem_next,
    input  logic [31:0] ir_mem_next,
    input  logic [31:0] y_mem_next,
    input  logic [31:0] st_mem_next,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] pc_wb_next,
    output logic [31:0] ir_wb_next,
    output logic [31:0] y_wb_next,
    output logic        fwd_mem_en,
    output logic [4:0]  fwd_mem_rc,
    output logic [31:0] fwd_mem_y
);

    logic [31:0] pc_mem_r;
    logic [31:0] ir_mem_r;
    logic [31:0] y_mem_r;
    logic [31:0] st_mem_r;

    logic [5:0]  opcode_s;
    logic        is_mem_s;
    logic        is_load_s;
    logic        done_s;
    logic        load_done_s;
    logic [31:0] result_s;

    // Stage registers: capture from execute unless the access is still outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_mem_r <= 32'h0000_0000;
            ir_mem_r <= NOP_INST;
            y_mem_r  <= 32'h0000_0000;
            st_mem_r <= 32'h0000_0000;
        end else if (!mem_stall) begin
            pc_mem_r <= pc_mem_next;
            ir_mem_r <= ir_mem_next;
            y_mem_r  <= y_mem_next;
            st_mem_r <= st_mem_next;
        end
    end

    assign opcode_s  = ir_mem_r[31:26];
    assign is_mem_s  = is_mem_op(opcode_s);
    assign is_load_s = is_load_op(opcode_s);

    memory_dmem_port u_dmem_port (
        .clk        (clk),
        .rst        (rst),
        .mem_op     (is_mem_s),
        .dmem_ready (dmem_ready),
        .dmem_req   (dmem_req),
        .mem_stall  (mem_stall),
        .done       (done_s)
    );

    // Request fields come straight from stage registers so they hold across waits.
    assign dmem_addr  = ALIGN_ADDR ? {y_mem_r[31:2], 2'b00} : y_mem_r;
    assign dmem_wdata = st_mem_r;
    assign dmem_we    = (opcode_s == OPCODE_ST);

    assign load_done_s = is_load_s & done_s;
    assign result_s    = load_done_s ? dmem_rdata : y_mem_r;

    assign pc_wb_next = pc_mem_r;
    assign ir_wb_next = mem_stall ? NOP_INST : ir_mem_r;
    assign y_wb_next  = result_s;

    // A load's value is only forwardable once the read data has arrived.
    assign fwd_mem_rc = ir_mem_r[25:21];
    assign fwd_mem_y  = result_s;
    assign fwd_mem_en = writes_rc(opcode_s) && (ir_mem_r[25:21] != REG_ZERO) &&
                        (!is_load_s || done_s);

endmodule

// File: tb/tb_memory.sv
// Randomized scoreboard bench for the memory stage, with an unaligned-address twin instance.
module tb_memory;

    localparam logic [31:0] NOP = 32'h83FFF800;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] y;
        logic [31:0] st;
        int          waits;
        logic [31:0] rdata;
    } instr_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] y;
        logic        req;
        logic        stall;
        logic        we;
        logic [31:0] addr;
        logic [31:0] addr_na;
        logic [31:0] wdata;
        logic        fen;
        logic [4:0]  frc;
        logic [31:0] fy;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_mem_next = '0, ir_mem_next = NOP, y_mem_next = '0, st_mem_next = '0;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;

    logic        a_stall, a_req, a_we, a_fen;
    logic [31:0] a_addr, a_wdata, a_pc, a_ir, a_y, a_fy;
    logic [4:0]  a_frc;
    logic        b_stall, b_req, b_we, b_fen;
    logic [31:0] b_addr, b_wdata, b_pc, b_ir, b_y, b_fy;
    logic [4:0]  b_frc;

    int checks = 0;
    int failures = 0;
    rec_t   exp_q[$];
    instr_t cur;

    always #5 clk = ~clk;

    memory #(.NOP_INST(NOP), .ALIGN_ADDR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .pc_mem_next(pc_mem_next), .ir_mem_next(ir_mem_next),
        .y_mem_next(y_mem_next), .st_mem_next(st_mem_next),
        .mem_stall(a_stall), .dmem_req(a_req), .dmem_we(a_we),
        .dmem_addr(a_addr), .dmem_wdata(a_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .pc_wb_next(a_pc), .ir_wb_next(a_ir), .y_wb_next(a_y),
        .fwd_mem_en(a_fen), .fwd_mem_rc(a_frc), .fwd_mem_y(a_fy)
    );

    memory #(.NOP_INST(NOP), .ALIGN_ADDR(1'b0)) dut_na (
        .clk(clk), .rst(rst),
        .pc_mem_next(pc_mem_next), .ir_mem_next(ir_mem_next),
        .y_mem_next(y_mem_next), .st_mem_next(st_mem_next),
        .mem_stall(b_stall), .dmem_req(b_req), .dmem_we(b_we),
        .dmem_addr(b_addr), .dmem_wdata(b_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .pc_wb_next(b_pc), .ir_wb_next(b_ir), .y_wb_next(b_y),
        .fwd_mem_en(b_fen), .fwd_mem_rc(b_frc), .fwd_mem_y(b_fy)
    );

    // Reference behaviour of one cycle, given the instruction sitting in the stage.
    function automatic rec_t model(input instr_t c, input logic rdy, input logic [31:0] rd);
        rec_t        e;
        logic [5:0]  op   = c.ir[31:26];
        logic        ld   = (op == 6'h18) || (op == 6'h1F);
        logic        mem  = ld || (op == 6'h19);
        logic        fin  = mem && rdy;
        logic        wr   = op[5] || ld || (op == 6'h1B) || (op == 6'h1C) || (op == 6'h1D);
        e.req     = mem;
        e.stall   = mem && !rdy;
        e.pc      = c.pc;
        e.ir      = e.stall ? NOP : c.ir;
        e.y       = (ld && fin) ? rd : c.y;
        e.we      = (op == 6'h19);
        e.addr    = c.y & 32'hFFFF_FFFC;
        e.addr_na = c.y;
        e.wdata   = c.st;
        e.frc     = c.ir[25:21];
        e.fen     = wr && (c.ir[25:21] != 5'd31) && (!ld || fin);
        e.fy      = e.y;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every negedge with a pending expectation, compare both instances.
    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ir_wb", a_ir, e.ir);
                chk("pc_wb", a_pc, e.pc);
                chk("y_wb", a_y, e.y);
                chk("req", {31'b0, a_req}, {31'b0, e.req});
                chk("stall", {31'b0, a_stall}, {31'b0, e.stall});
                chk("fwd_en", {31'b0, a_fen}, {31'b0, e.fen});
                chk("fwd_rc", {27'b0, a_frc}, {27'b0, e.frc});
                chk("fwd_y", a_fy, e.fy);
                chk("na_ir_wb", b_ir, e.ir);
                chk("na_y_wb", b_y, e.y);
                chk("na_stall", {31'b0, b_stall}, {31'b0, e.stall});
                chk("na_fwd_en", {31'b0, b_fen}, {31'b0, e.fen});
                chk("na_pc_fwd", b_pc ^ b_fy, e.pc ^ e.fy);
                chk("na_rc", {26'b0, b_frc, b_req}, {26'b0, e.frc, e.req});
                if (e.req) begin
                    chk("we", {31'b0, a_we}, {31'b0, e.we});
                    chk("addr", a_addr, e.addr);
                    chk("wdata", a_wdata, e.wdata);
                    chk("na_addr", b_addr, e.addr_na);
                    chk("na_we_wdata", b_wdata ^ {31'b0, b_we}, e.wdata ^ {31'b0, e.we});
                end
            end
        end
    end

    // One stage cycle: present execute's next values and memory response, log expectation.
    task automatic tick(input instr_t nxt, input logic rdy, input logic [31:0] rd);
        pc_mem_next = nxt.pc;
        ir_mem_next = nxt.ir;
        y_mem_next  = nxt.y;
        st_mem_next = nxt.st;
        dmem_ready  = rdy;
        dmem_rdata  = rd;
        exp_q.push_back(model(cur, rdy, rd));
        @(posedge clk);
        #1;
    endtask

    // Retire the current instruction (with its wait cycles) while nxt waits in execute.
    task automatic step(input instr_t nxt);
        logic [5:0] op = cur.ir[31:26];
        bit mem = (op == 6'h18) || (op == 6'h19) || (op == 6'h1F);
        if (mem) begin
            for (int w = 0; w < cur.waits; w++) tick(nxt, 1'b0, $urandom);
            tick(nxt, 1'b1, cur.rdata);
        end else begin
            tick(nxt, 1'($urandom_range(0, 1)), $urandom);
        end
        cur = nxt;
    endtask

    function automatic instr_t mk(input logic [31:0] ir, input logic [31:0] y,
                                  input logic [31:0] st, input int waits,
                                  input logic [31:0] rd);
        instr_t i;
        i.pc = $urandom & 32'hFFFF_FFFC;
        i.ir = ir; i.y = y; i.st = st; i.waits = waits; i.rdata = rd;
        return i;
    endfunction

    function automatic instr_t rnd();
        logic [5:0] ops[10] = '{6'h18, 6'h19, 6'h1F, 6'h1B, 6'h1C, 6'h1D, 6'h20, 6'h31, 6'h01, 6'h3A};
        logic [4:0] rc = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom);
        return mk({ops[$urandom_range(0, 9)], rc, 21'($urandom)}, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom);
    endfunction

    initial begin
        instr_t nop0;
        nop0 = '{pc: 32'h0, ir: NOP, y: 32'h0, st: 32'h0, waits: 0, rdata: 32'h0};
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cur = nop0;
        step(mk({6'h20, 5'd3, 5'd1, 5'd2, 11'd0}, 32'd3, 32'h0, 0, 32'h0));
        step(mk({6'h18, 5'd4, 5'd0, 16'h0100}, 32'h100, 32'h0, 0, 32'hDEADBEEF));
        step(mk({6'h19, 5'd5, 5'd0, 16'h0204}, 32'h204, 32'h12345678, 2, 32'h0));
        step(mk({6'h18, 5'd6, 5'd0, 16'h0107}, 32'h107, 32'h0, 1, 32'hCAFEF00D));
        step(mk({6'h1F, 5'd7, 5'd0, 16'h0010}, 32'h10, 32'h0, 0, 32'h0BADF00D));
        for (int n = 0; n < 300; n++) step(rnd());
        // Reset while a load sits in WAIT.
        step(mk({6'h18, 5'd8, 5'd0, 16'h0300}, 32'h300, 32'h0, 9, 32'h0));
        tick(nop0, 1'b0, $urandom);
        rst = 1'b1;
        tick(nop0, 1'b0, $urandom);
        rst = 1'b0;
        cur = nop0;
        tick(nop0, 1'b1, $urandom);
        tick(nop0, 1'b0, $urandom);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
